seg_display_ctrl: RTL and testbench
===================================

Name: seg_display_ctrl

Overview:
Sequencer for the single-digit seven-segment decoder. It latches the value written by the processor and drives the decoder's value, bit-array, animation-enable and display-on inputs. It also schedules a timed "spinner" animation and an optional blink of the static value. The block sits between the core's output register write and the segment decoder. All outputs connect directly to the decoder's inputs.

Parameters:
TICK_DIV, 4, clock cycles per animation/blink step (>=2; silicon builds override to ~50000)
ANIM_LAPS, 2, full spinner rotations per animation request (>=1)
BLINK_STEPS, 4, ticks per blink half-period (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en_in  input  1  display enable; 0 forces display off
wr_en_in  input  1  load wr_data_in into value register this edge
wr_data_in  input  5  [3:0] hex digit, [4] decimal point
anim_req_in  input  1  single-cycle pulse: start/restart spinner
blink_en_in  input  1  blink static value while 1
value_out  output  5  to decoder value input
bit_array_out  output  8  to decoder raw segment input
anim_en_out  output  1  to decoder animation select
display_on_out  output  1  to decoder display enable
busy_out  output  1  1 while spinner runs

Behaviour:
- Reset (rst_n=0, async): state=OFF, value reg=0, prescaler=0, step=0, lap=0, blink counter=0, blink phase=1. All outputs=0.
- Prescaler: counts 0..TICK_DIV-1 while state!=OFF. tick=1 for the single cycle where count==TICK_DIV-1, then the count wraps to 0. Cleared to 0 on entry to OFF and on each accepted anim_req_in.
- Value register: loads on any edge with wr_en_in=1, in every state including OFF. value_out reflects it the cycle after the edge. Retained through OFF.
- FSM states OFF, SHOW, SPIN:
  - OFF: en_in=1 -> SHOW.
  - SHOW: en_in=0 -> OFF. Otherwise anim_req_in=1 -> SPIN with step=0, lap=0.
  - SPIN: en_in=0 -> OFF. anim_req_in=1 -> stay in SPIN, step=0, lap=0 (restart).
  - SPIN, on tick: step increments. At step==5, step wraps to 0 and lap increments. When step==5 and lap==ANIM_LAPS-1, go to SHOW instead.
- Event priority in the same cycle: en_in=0 over anim_req_in over tick.
- Transitions occur on the clock edge; outputs are decoded from registered state (no combinational path from inputs).
- Output decode:
  - anim_en_out=1 and busy_out=1 iff state==SPIN.
  - bit_array_out in SPIN: one-hot bit[step], with bit0=top segment, bit1=top-right … bit5=top-left (clockwise); bits 7:6=0. bit_array_out=0 outside SPIN.
  - display_on_out=0 in OFF, 1 in SPIN, and equal to blink phase in SHOW.
- Blink:
  - Active only in SHOW with blink_en_in=1. The blink counter advances on tick.
  - When the counter reaches BLINK_STEPS-1, it wraps to 0 and the phase toggles.
  - blink_en_in=0, or any state other than SHOW: counter=0, phase=1. Every blink therefore starts with a full on half-period.
- Width rules: step is 3 bits (0..5 only). lap is wide enough for ANIM_LAPS-1. The prescaler is sized from TICK_DIV. No overflow is possible.
- wr_en_in during SPIN updates the register silently; the new value shows on return to SHOW.

Test Plan:
1. Reset mid-SPIN (rst_n low at step 3) -> all outputs 0 immediately (async), state OFF. After release with en_in=1 -> SHOW next edge, display_on_out=1.
2. en_in=1, write 5'b1_0111 -> next cycle value_out=0x17, display_on_out=1, anim_en_out=0, bit_array_out=0.
3. anim_req_in pulse, TICK_DIV=4, ANIM_LAPS=2 -> bit_array_out steps 0x01,0x02,0x04,0x08,0x10,0x20 with each value held 4 cycles, sequence repeated twice (48 cycles). Then anim_en_out=0, busy_out=0.
4. anim_req_in pulse at lap 1, step 4 -> bit_array_out returns to 0x01 with a full 4-cycle hold, and two more full laps follow. Same-cycle en_in=0 plus anim_req_in -> OFF.
5. blink_en_in=1 in SHOW, BLINK_STEPS=4, TICK_DIV=4 -> display_on_out high 16 cycles, low 16, repeating. Dropping blink_en_in while low -> display_on_out=1 next cycle.
6. en_in=0 during SPIN, then en_in=1 -> OFF with display_on_out=0, then SHOW with value_out unchanged and busy_out=0.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: sequencer in front of the single-digit seven-segment decoder.
// Holds the processor-written value, runs a timed clockwise "spinner" animation
// on request, and optionally blinks the static value. All outputs are registered
// and computed from the next-state values, so they track the state registers exactly.
module seg_display_ctrl #(
    parameter int TICK_DIV    = 4,
    parameter int ANIM_LAPS   = 2,
    parameter int BLINK_STEPS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_in,
    input  logic       wr_en_in,
    input  logic [4:0] wr_data_in,
    input  logic       anim_req_in,
    input  logic       blink_en_in,
    output logic [4:0] value_out,
    output logic [7:0] bit_array_out,
    output logic       anim_en_out,
    output logic       display_on_out,
    output logic       busy_out
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int LW = (ANIM_LAPS > 1) ? $clog2(ANIM_LAPS) : 1;
    localparam int BW = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [LW-1:0] LAP_MAX   = LW'(ANIM_LAPS - 1);
    localparam logic [LW-1:0] LAP_ONE   = LW'(1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_STEPS - 1);
    localparam logic [BW-1:0] BLINK_ONE = BW'(1);
    localparam logic [2:0]    STEP_LAST = 3'd5;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_SPIN = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [PW-1:0]   presc_r, presc_s;
    logic [2:0]      step_r, step_s;
    logic [LW-1:0]   lap_r, lap_s;
    logic [BW-1:0]   blink_cnt_r, blink_cnt_s;
    logic            blink_phase_r, blink_phase_s;
    logic            tick_s;
    logic [4:0]      value_r;
    logic [7:0]      bits_r;
    logic            anim_r;
    logic            disp_r;

    // Next-state logic: priority is display disable, then animation request, then tick.
    always_comb begin
        state_s       = state_r;
        presc_s       = presc_r;
        step_s        = step_r;
        lap_s         = lap_r;
        blink_cnt_s   = '0;
        blink_phase_s = 1'b1;
        tick_s        = (state_r != ST_OFF) && (presc_r == PRESC_MAX);

        if (state_r == ST_OFF) begin
            presc_s = '0;
        end else if (tick_s) begin
            presc_s = '0;
        end else begin
            presc_s = presc_r + PRESC_ONE;
        end

        case (state_r)
            ST_OFF: begin
                if (en_in) begin
                    state_s = ST_SHOW;
                end else begin
                    state_s = ST_OFF;
                end
            end
            ST_SHOW: begin
                if (!en_in) begin
                    state_s = ST_OFF;
                    presc_s = '0;
                end else if (anim_req_in) begin
                    state_s = ST_SPIN;
                    presc_s = '0;
                    step_s  = 3'd0;
                    lap_s   = '0;
                end else if (blink_en_in) begin
                    if (tick_s) begin
                        if (blink_cnt_r == BLINK_MAX) begin
                            blink_cnt_s   = '0;
                            blink_phase_s = ~blink_phase_r;
                        end else begin
                            blink_cnt_s   = blink_cnt_r + BLINK_ONE;
                            blink_phase_s = blink_phase_r;
                        end
                    end else begin
                        blink_cnt_s   = blink_cnt_r;
                        blink_phase_s = blink_phase_r;
                    end
                end else begin
                    state_s = ST_SHOW;
                end
            end
            ST_SPIN: begin
                if (!en_in) begin
                    state_s = ST_OFF;
                    presc_s = '0;
                    step_s  = 3'd0;
                    lap_s   = '0;
                end else if (anim_req_in) begin
                    presc_s = '0;
                    step_s  = 3'd0;
                    lap_s   = '0;
                end else if (tick_s) begin
                    if (step_r == STEP_LAST) begin
                        step_s = 3'd0;
                        if (lap_r == LAP_MAX) begin
                            state_s = ST_SHOW;
                            lap_s   = '0;
                        end else begin
                            lap_s = lap_r + LAP_ONE;
                        end
                    end else begin
                        step_s = step_r + 3'd1;
                    end
                end else begin
                    state_s = ST_SPIN;
                end
            end
            default: begin
                state_s = ST_OFF;
                presc_s = '0;
                step_s  = 3'd0;
                lap_s   = '0;
            end
        endcase
    end

    // State registers and output registers decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_OFF;
            presc_r       <= '0;
            step_r        <= 3'd0;
            lap_r         <= '0;
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b1;
            bits_r        <= 8'd0;
            anim_r        <= 1'b0;
            disp_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            presc_r       <= presc_s;
            step_r        <= step_s;
            lap_r         <= lap_s;
            blink_cnt_r   <= blink_cnt_s;
            blink_phase_r <= blink_phase_s;
            anim_r        <= (state_s == ST_SPIN);
            bits_r        <= (state_s == ST_SPIN) ? (8'd1 << step_s) : 8'd0;
            case (state_s)
                ST_OFF:  disp_r <= 1'b0;
                ST_SPIN: disp_r <= 1'b1;
                ST_SHOW: disp_r <= blink_phase_s;
                default: disp_r <= 1'b0;
            endcase
        end
    end

    // Value register: written in any state, kept through OFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= 5'd0;
        end else if (wr_en_in) begin
            value_r <= wr_data_in;
        end else begin
            value_r <= value_r;
        end
    end

    assign value_out      = value_r;
    assign bit_array_out  = bits_r;
    assign anim_en_out    = anim_r;
    assign busy_out       = anim_r;
    assign display_on_out = disp_r;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl with a behavioural reference model
// that tracks elapsed cycles and tick counts rather than step/lap counters.
module tb_seg_display_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int ANIM_LAPS   = 2;
    localparam int BLINK_STEPS = 4;
    localparam int SPIN_CYCLES = 6 * TICK_DIV * ANIM_LAPS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_in = 1'b0;
    logic       wr_en_in = 1'b0;
    logic [4:0] wr_data_in = 5'd0;
    logic       anim_req_in = 1'b0;
    logic       blink_en_in = 1'b0;
    logic [4:0] value_out;
    logic [7:0] bit_array_out;
    logic       anim_en_out;
    logic       display_on_out;
    logic       busy_out;
    logic [15:0] obs;

    int total = 0;
    int bad = 0;

    // Model: 0=OFF 1=SHOW 2=SPIN; pc = cycles since prescaler clear,
    // el = cycles since spinner start, bt = ticks since blink start.
    int         m_st = 0;
    int         m_pc = 0;
    int         m_el = 0;
    int         m_bt = 0;
    logic [4:0] m_val = 5'd0;

    seg_display_ctrl #(
        .TICK_DIV(TICK_DIV), .ANIM_LAPS(ANIM_LAPS), .BLINK_STEPS(BLINK_STEPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en_in(en_in), .wr_en_in(wr_en_in),
        .wr_data_in(wr_data_in), .anim_req_in(anim_req_in), .blink_en_in(blink_en_in),
        .value_out(value_out), .bit_array_out(bit_array_out), .anim_en_out(anim_en_out),
        .display_on_out(display_on_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    assign obs = {value_out, bit_array_out, anim_en_out, busy_out, display_on_out};

    task automatic model_reset();
        m_st = 0; m_pc = 0; m_el = 0; m_bt = 0; m_val = 5'd0;
    endtask

    task automatic model_edge();
        logic tick;
        if (!rst_n) begin
            model_reset();
        end else begin
            tick = (m_st != 0) && ((m_pc % TICK_DIV) == TICK_DIV - 1);
            if (wr_en_in) m_val = wr_data_in;
            case (m_st)
                0: begin
                    if (en_in) m_st = 1;
                    m_pc = 0; m_bt = 0;
                end
                1: begin
                    if (!en_in) begin
                        m_st = 0; m_pc = 0; m_bt = 0;
                    end else if (anim_req_in) begin
                        m_st = 2; m_el = 0; m_pc = 0; m_bt = 0;
                    end else begin
                        m_pc++;
                        if (!blink_en_in) m_bt = 0;
                        else if (tick) m_bt++;
                    end
                end
                default: begin
                    m_bt = 0;
                    if (!en_in) begin
                        m_st = 0; m_pc = 0;
                    end else if (anim_req_in) begin
                        m_el = 0; m_pc = 0;
                    end else begin
                        m_pc++; m_el++;
                        if (m_el == SPIN_CYCLES) m_st = 1;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [15:0] exp_vec();
        logic [7:0] b;
        logic a, d;
        a = (m_st == 2);
        b = a ? (8'd1 << ((m_el / TICK_DIV) % 6)) : 8'd0;
        if (m_st == 0) d = 1'b0;
        else if (a) d = 1'b1;
        else d = (((m_bt / BLINK_STEPS) % 2) == 0);
        return {m_val, b, a, a, d};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (obs !== 16'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0000", obs); end
        cyc(); cyc();
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, exp_vec()); end
        rst_n = 1'b1; en_in = 1'b1;
        cyc();
        total++;
        if (display_on_out !== 1'b1 || obs !== exp_vec())
            begin bad++; $display("FAIL reset_to_show got=%h want=%h", obs, exp_vec()); end
    endtask

    task automatic test_write();
        wr_en_in = 1'b1; wr_data_in = 5'b1_0111;
        cyc();
        wr_en_in = 1'b0;
        total++;
        if (value_out !== 5'h17 || display_on_out !== 1'b1 || anim_en_out !== 1'b0 || bit_array_out !== 8'd0)
            begin bad++; $display("FAIL write_value got=%h want=17 on=1 anim=0 bits=00", obs); end
    endtask

    task automatic test_spin();
        logic [7:0] want;
        anim_req_in = 1'b1;
        cyc();
        anim_req_in = 1'b0;
        for (int i = 0; i < SPIN_CYCLES; i++) begin
            want = 8'd1 << ((i / TICK_DIV) % 6);
            total++;
            if (bit_array_out !== want || busy_out !== 1'b1)
                begin bad++; $display("FAIL spin_seq cyc=%0d got=%h busy=%b want=%h", i, bit_array_out, busy_out, want); end
            cyc();
        end
        total++;
        if (anim_en_out !== 1'b0 || busy_out !== 1'b0 || bit_array_out !== 8'd0)
            begin bad++; $display("FAIL spin_end got=%h want anim=0 busy=0", obs); end
    endtask

    task automatic test_restart();
        anim_req_in = 1'b1;
        cyc();
        anim_req_in = 1'b0;
        for (int i = 0; i < 6 * TICK_DIV + 4 * TICK_DIV; i++) cyc();
        total++;
        if (bit_array_out !== 8'h10) begin bad++; $display("FAIL restart_pre got=%h want=10", bit_array_out); end
        anim_req_in = 1'b1;
        cyc();
        anim_req_in = 1'b0;
        for (int i = 0; i < SPIN_CYCLES + 3; i++) begin
            if (i < TICK_DIV) begin
                total++;
                if (bit_array_out !== 8'h01) begin bad++; $display("FAIL restart_hold cyc=%0d got=%h want=01", i, bit_array_out); end
            end
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL restart_laps cyc=%0d got=%h want=%h", i, obs, exp_vec()); end
            cyc();
        end
        anim_req_in = 1'b1;
        cyc();
        anim_req_in = 1'b1; en_in = 1'b0;
        cyc();
        anim_req_in = 1'b0;
        total++;
        if (display_on_out !== 1'b0 || anim_en_out !== 1'b0 || obs !== exp_vec())
            begin bad++; $display("FAIL off_priority got=%h want=%h", obs, exp_vec()); end
        en_in = 1'b1;
        cyc();
    endtask

    task automatic test_blink();
        int n;
        blink_en_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL blink_model cyc=%0d got=%h want=%h", i, obs, exp_vec()); end
            cyc();
        end
        n = 0;
        while (display_on_out !== 1'b0 && n < 40) begin n++; cyc(); end
        n = 0;
        while (display_on_out === 1'b0 && n < 40) begin n++; cyc(); end
        total++;
        if (n != TICK_DIV * BLINK_STEPS) begin bad++; $display("FAIL blink_low_len got=%0d want=%0d", n, TICK_DIV * BLINK_STEPS); end
        n = 0;
        while (display_on_out === 1'b1 && n < 40) begin n++; cyc(); end
        total++;
        if (n != TICK_DIV * BLINK_STEPS) begin bad++; $display("FAIL blink_high_len got=%0d want=%0d", n, TICK_DIV * BLINK_STEPS); end
        cyc();
        blink_en_in = 1'b0;
        cyc();
        total++;
        if (display_on_out !== 1'b1 || obs !== exp_vec())
            begin bad++; $display("FAIL blink_drop got=%h want=%h", obs, exp_vec()); end
    endtask

    task automatic test_off_during_spin();
        logic [4:0] saved;
        anim_req_in = 1'b1;
        cyc();
        anim_req_in = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        wr_en_in = 1'b1; wr_data_in = 5'h0A;
        cyc();
        wr_en_in = 1'b0;
        saved = 5'h0A;
        en_in = 1'b0;
        cyc();
        total++;
        if (display_on_out !== 1'b0 || busy_out !== 1'b0 || obs !== exp_vec())
            begin bad++; $display("FAIL spin_to_off got=%h want=%h", obs, exp_vec()); end
        en_in = 1'b1;
        cyc();
        total++;
        if (display_on_out !== 1'b1 || busy_out !== 1'b0 || value_out !== saved)
            begin bad++; $display("FAIL off_to_show got=%h want value=%h on=1 busy=0", obs, saved); end
    endtask

    task automatic test_reset_mid_spin();
        anim_req_in = 1'b1;
        cyc();
        anim_req_in = 1'b0;
        for (int i = 0; i < 3 * TICK_DIV; i++) cyc();
        total++;
        if (bit_array_out !== 8'h08) begin bad++; $display("FAIL mid_spin_step3 got=%h want=08", bit_array_out); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs !== 16'd0) begin bad++; $display("FAIL async_reset got=%h want=0000", obs); end
        #1 rst_n = 1'b1;
        cyc();
        total++;
        if (display_on_out !== 1'b1 || obs !== exp_vec())
            begin bad++; $display("FAIL reset_release got=%h want=%h", obs, exp_vec()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            en_in       = ($urandom_range(0, 39) != 0);
            anim_req_in = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) blink_en_in = ~blink_en_in;
            wr_en_in    = ($urandom_range(0, 9) == 0);
            wr_data_in  = 5'($urandom);
            cyc();
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_spin();
        test_restart();
        test_blink();
        test_off_during_spin();
        test_reset_mid_spin();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
